wb_burst_read: RTL and testbench

WB_BURST_READ -- requirements
Module: wb_burst_read

---
 rtl/wb_burst_read_pkg.sv | 21 ++
 rtl/wb_burst_read_if.sv | 29 ++
 rtl/wb_fifo.sv | 57 +++++
 rtl/wb_burst_read.sv | 208 ++++++++++++++++++++
 tb/tb_wb_burst_read.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_burst_read_pkg.sv
// Shared definitions for the Wishbone burst read master: FSM encoding and default sizes.
package wb_burst_read_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ABITS = 12;
    localparam int DEF_CBITS = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_DELAY = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // True when n is a nonzero power of two (FIFO pointers rely on natural wrap).
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/wb_burst_read_if.sv
// Wishbone B4 pipelined read bus between the burst master and a slave.
interface wb_burst_read_if
    import wb_burst_read_pkg::*;
#(
    parameter int ABITS = DEF_ABITS,
    parameter int WIDTH = DEF_WIDTH
);

    logic             cyc_o;
    logic             stb_o;
    logic             we_o;
    logic [ABITS-1:0] adr_o;
    logic             ack_i;
    logic             wat_i;
    logic             rty_i;
    logic             err_i;
    logic [WIDTH-1:0] dat_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o,
        input  ack_i, wat_i, rty_i, err_i, dat_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o,
        output ack_i, wat_i, rty_i, err_i, dat_i
    );

endinterface

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO with show-ahead head; push and pop may coincide when full or empty.
module wb_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign valid_o = (level_o != '0);
    assign full    = (level_o == LW'(DEPTH));
    assign pop_ok  = pop_i & valid_o;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign push_ok = push_i & (~full | pop_ok);
    assign dout_o  = mem[rptr];

    // Storage is never reset: only occupied entries are ever presented.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wptr] <= din_i;
        end
    end

    // Pointers and occupancy; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr    <= '0;
            rptr    <= '0;
            level_o <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            level_o <= level_o + LW'(push_ok) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/wb_burst_read.sv
// Wishbone B4 pipelined burst read master feeding a valid/ready output stream.
module wb_burst_read
    import wb_burst_read_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ABITS = DEF_ABITS,
    parameter int CBITS = DEF_CBITS,
    parameter int DEPTH = DEF_DEPTH,
    parameter int DELAY = DEF_DELAY
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [ABITS-1:0]   base_i,
    input  logic [CBITS-1:0]   count_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               fail_o,
    wb_burst_read_if.master    wb,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               last_o
);

    localparam int CW = CBITS + 1;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef logic [CW-1:0] cnt_t;

    if (!is_pow2(DEPTH) || DELAY < 0) begin : g_param_check
        $error("wb_burst_read: DEPTH must be a power of two and DELAY non-negative");
    end

    state_e         state_q;
    state_e         state_d;
    cnt_t           cnt_q;
    cnt_t           issued_q;
    cnt_t           pending_q;
    cnt_t           rcvd_q;
    cnt_t           issued_n;
    cnt_t           pending_n;
    cnt_t           fcount_n;
    logic           accept;
    logic           abort;
    logic           ack_ok;
    logic           push;
    logic           pop;
    logic           last_push;
    logic           room_run;
    logic           room_idle;
    logic           cyc_d;
    logic           stb_d;
    logic           busy_d;
    logic           done_d;
    logic           fail_d;
    logic [WIDTH:0] head;
    logic [LW-1:0]  fifo_level;

    assign wb.we_o = 1'b0;

    // Bus events this cycle. Acks with nothing outstanding are ignored.
    assign accept    = wb.stb_o & ~wb.wat_i;
    assign abort     = wb.cyc_o & (wb.err_i | wb.rty_i);
    assign ack_ok    = wb.cyc_o & wb.ack_i & (pending_q != '0);
    assign push      = ack_ok & ~abort;
    assign pop       = valid_o & ready_i;
    assign last_push = push & (rcvd_q == cnt_q - cnt_t'(1));

    // Look-ahead counts so the registered strobe reflects next-cycle occupancy.
    assign issued_n  = issued_q + cnt_t'(accept);
    assign pending_n = pending_q + cnt_t'(accept) - cnt_t'(ack_ok);
    assign fcount_n  = cnt_t'(fifo_level) + cnt_t'(push) - cnt_t'(pop);
    assign room_run  = (pending_n + fcount_n) < cnt_t'(DEPTH);
    assign room_idle = fcount_n < cnt_t'(DEPTH);

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i && count_i != '0) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept && issued_n == cnt_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort || pending_n == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered bus and status outputs.
    always_comb begin
        cyc_d  = 1'b0;
        stb_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        fail_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (count_i != '0) begin
                        cyc_d  = 1'b1;
                        busy_d = 1'b1;
                        stb_d  = room_idle;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ISSUE, ST_DRAIN: begin
                if (abort) begin
                    done_d = 1'b1;
                    fail_d = 1'b1;
                end else if (state_d == ST_IDLE) begin
                    done_d = 1'b1;
                end else begin
                    cyc_d  = 1'b1;
                    busy_d = 1'b1;
                    stb_d  = (state_d == ST_ISSUE) && (issued_n < cnt_q) && room_run;
                end
            end
            default: ;
        endcase
    end

    // Registered bus control and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb.cyc_o <= 1'b0;
            wb.stb_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            fail_o   <= 1'b0;
        end else begin
            wb.cyc_o <= cyc_d;
            wb.stb_o <= stb_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
            fail_o   <= fail_d;
        end
    end

    // Address and burst counters; a new burst reloads them from the start request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb.adr_o  <= '0;
            cnt_q     <= '0;
            issued_q  <= '0;
            pending_q <= '0;
            rcvd_q    <= '0;
        end else if (state_q == ST_IDLE) begin
            if (start_i && count_i != '0) begin
                wb.adr_o  <= base_i;
                cnt_q     <= {1'b0, count_i};
                issued_q  <= '0;
                pending_q <= '0;
                rcvd_q    <= '0;
            end
        end else begin
            if (accept) begin
                wb.adr_o <= wb.adr_o + ABITS'(1);
            end
            issued_q  <= issued_n;
            pending_q <= pending_n;
            if (push) begin
                rcvd_q <= rcvd_q + cnt_t'(1);
            end
        end
    end

    wb_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .din_i   ({last_push, wb.dat_i}),
        .pop_i   (pop),
        .dout_o  (head),
        .valid_o (valid_o),
        .level_o (fifo_level)
    );

    assign data_o = head[WIDTH-1:0];
    assign last_o = valid_o & head[WIDTH];

endmodule

// File: tb/tb_wb_burst_read.sv
// Directed bench for wb_burst_read: table of bursts plus timed corner sequences.
module tb_wb_burst_read;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic [11:0] base_i;
    logic [7:0]  count_i;
    logic        busy_o;
    logic        done_o;
    logic        fail_o;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  data_o;
    logic        last_o;

    wb_burst_read_if #(.ABITS(12), .WIDTH(8)) bus ();

    wb_burst_read dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .base_i  (base_i),
        .count_i (count_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .fail_o  (fail_o),
        .wb      (bus),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .last_o  (last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Slave model state and logs
    logic [11:0] stb_log[$];
    logic [7:0]  wd_log[$];
    logic        wl_log[$];
    bit          acc_pend = 1'b0;
    logic [7:0]  acc_dat  = '0;
    int          ack_num  = 0;
    int          err_ack  = 0;
    int          rty_ack  = 0;
    int          stall_left = 0;
    logic [11:0] stall_adr = '0;
    int          n_stall = 0;
    int          n_stall_bad = 0;
    int          n_done = 0;
    int          n_fail = 0;

    typedef struct {
        logic [11:0] base;
        logic [7:0]  count;
        int          stall;
        int          err_ack;
        int          rty_ack;
        int          exp_stb;
        int          exp_words;
        int          exp_last_idx;
        bit          exp_fail;
        int          exp_stall;
    } vec_t;

    vec_t vecs[9];

    // Pipelined slave: ack one cycle after each accepted strobe; also logs the stream.
    always @(negedge clk) begin
        if (!rst_ni) begin
            bus.ack_i = 1'b0;
            bus.err_i = 1'b0;
            bus.rty_i = 1'b0;
            bus.wat_i = 1'b0;
            bus.dat_i = '0;
            acc_pend  = 1'b0;
        end else begin
            bus.ack_i = acc_pend;
            if (acc_pend) begin
                ack_num++;
                bus.dat_i = acc_dat;
            end
            bus.err_i = acc_pend && (ack_num == err_ack);
            bus.rty_i = acc_pend && (ack_num == rty_ack);
            bus.wat_i = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            acc_pend = bus.cyc_o && bus.stb_o && !bus.wat_i;
            if (acc_pend) begin
                stb_log.push_back(bus.adr_o);
                acc_dat = bus.adr_o[7:0] ^ 8'hA5;
            end
            if (bus.cyc_o && bus.stb_o && bus.wat_i) begin
                n_stall++;
                if (bus.adr_o != stall_adr) n_stall_bad++;
            end
            if (valid_o && ready_i) begin
                wd_log.push_back(data_o);
                wl_log.push_back(last_o);
            end
            if (done_o) n_done++;
            if (fail_o) n_fail++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_dat(input logic [11:0] base, input int k);
        logic [11:0] a;
        a = 12'(base + k);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic clear_logs();
        stb_log.delete();
        wd_log.delete();
        wl_log.delete();
        ack_num     = 0;
        n_stall     = 0;
        n_stall_bad = 0;
    endtask

    task automatic wait_done(input int d0, input int limit);
        int c = 0;
        while (n_done == d0 && c < limit) begin
            tick();
            c++;
        end
    endtask

    task automatic check_burst(input int id, input logic [11:0] base, input int exp_stb,
                               input int exp_words, input int exp_last_idx, input bit exp_fail,
                               input int d0, input int f0);
        int bad_adr  = 0;
        int bad_dat  = 0;
        int bad_last = 0;
        chk($sformatf("b%0d_done_cnt", id), n_done - d0, 1);
        chk($sformatf("b%0d_fail_cnt", id), n_fail - f0, exp_fail);
        chk($sformatf("b%0d_strobes", id), stb_log.size(), exp_stb);
        chk($sformatf("b%0d_words", id), wd_log.size(), exp_words);
        for (int k = 0; k < stb_log.size(); k++)
            if (stb_log[k] != 12'(base + k)) bad_adr++;
        for (int k = 0; k < wd_log.size(); k++) begin
            if (wd_log[k] != exp_dat(base, k)) bad_dat++;
            if (wl_log[k] != (k == exp_last_idx)) bad_last++;
        end
        chk($sformatf("b%0d_adr_seq_errs", id), bad_adr, 0);
        chk($sformatf("b%0d_data_errs", id), bad_dat, 0);
        chk($sformatf("b%0d_last_errs", id), bad_last, 0);
    endtask

    initial begin
        int d0;
        int f0;

        //            base    count stall err rty  stb  wrd  last fail stall
        vecs[0] = '{12'h100, 8'd3,   0,   0,  0,   3,   3,   2,  1'b0, 0};
        vecs[1] = '{12'h200, 8'd8,   0,   0,  0,   8,   8,   7,  1'b0, 0};
        vecs[2] = '{12'h300, 8'd5,   4,   0,  0,   5,   5,   4,  1'b0, 3};
        vecs[3] = '{12'h400, 8'd4,   0,   2,  0,   3,   1,  -1,  1'b1, 0};
        vecs[4] = '{12'hFFE, 8'd4,   0,   0,  0,   4,   4,   3,  1'b0, 0};
        vecs[5] = '{12'h500, 8'd2,   0,   0,  1,   2,   0,  -1,  1'b1, 0};
        vecs[6] = '{12'h0A0, 8'd0,   0,   0,  0,   0,   0,  -1,  1'b0, 0};
        vecs[7] = '{12'h7FF, 8'd1,   0,   0,  0,   1,   1,   0,  1'b0, 0};
        vecs[8] = '{12'h000, 8'd255, 0,   0,  0, 255, 255, 254,  1'b0, 0};

        rst_ni  = 1'b0;
        start_i = 1'b0;
        base_i  = '0;
        count_i = '0;
        ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            {bus.cyc_o, bus.stb_o, bus.we_o, busy_o, done_o, fail_o, valid_o, last_o}, 0);
        chk("reset_adr", bus.adr_o, 0);
        rst_ni = 1'b1;
        tick();

        // Timed three-word burst with ack one cycle after each strobe
        clear_logs();
        d0 = n_done; f0 = n_fail;
        ready_i = 1'b1; base_i = 12'h100; count_i = 8'd3; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("t3_cyc_busy_stb", {bus.cyc_o, busy_o, bus.stb_o}, 3'b111);
        chk("t3_adr0", bus.adr_o, 12'h100);
        tick();
        chk("t3_adr1", bus.adr_o, 12'h101);
        tick();
        chk("t3_word0_timing", {valid_o, last_o, data_o}, {1'b1, 1'b0, 8'hA5});
        tick();
        tick();
        chk("t3_done_state", {done_o, fail_o, bus.cyc_o, busy_o}, 4'b1000);
        chk("t3_last_word", {valid_o, last_o, data_o}, {1'b1, 1'b1, 8'hA7});
        tick();
        chk("t3_done_pulse_end", {done_o, valid_o}, 2'b00);
        check_burst(100, 12'h100, 3, 3, 2, 1'b0, d0, f0);

        // Zero-length burst: done pulse one cycle after start, no bus cycle
        clear_logs();
        base_i = 12'h123; count_i = 8'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("z_done_next_cycle", {done_o, fail_o, bus.cyc_o, busy_o, bus.stb_o}, 5'b10000);
        tick();
        chk("z_done_one_cycle", done_o, 0);

        // Back-pressure: FIFO depth limits outstanding strobes; start ignored while busy
        clear_logs();
        d0 = n_done; f0 = n_fail;
        ready_i = 1'b0; base_i = 12'h600; count_i = 8'd8; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        base_i = 12'h7AA; count_i = 8'd2; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (15) tick();
        chk("bp_strobes_held", stb_log.size(), 4);
        chk("bp_stb_low", {bus.stb_o, bus.cyc_o, busy_o}, 3'b011);
        chk("bp_head", {valid_o, data_o}, {1'b1, 8'hA5});
        ready_i = 1'b1;
        wait_done(d0, 100);
        repeat (8) tick();
        check_burst(200, 12'h600, 8, 8, 7, 1'b0, d0, f0);

        // Table of bursts
        for (int i = 0; i < 9; i++) begin
            clear_logs();
            d0 = n_done; f0 = n_fail;
            err_ack    = vecs[i].err_ack;
            rty_ack    = vecs[i].rty_ack;
            stall_left = vecs[i].stall;
            stall_adr  = vecs[i].base;
            ready_i = 1'b1;
            base_i  = vecs[i].base;
            count_i = vecs[i].count;
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            wait_done(d0, 1000);
            repeat (8) tick();
            check_burst(i, vecs[i].base, vecs[i].exp_stb, vecs[i].exp_words,
                        vecs[i].exp_last_idx, vecs[i].exp_fail, d0, f0);
            chk($sformatf("b%0d_stall_cycles", i), n_stall, vecs[i].exp_stall);
            chk($sformatf("b%0d_stall_adr_errs", i), n_stall_bad, 0);
        end
        err_ack = 0;
        rty_ack = 0;

        // Reset in the middle of a burst with words waiting in the FIFO
        clear_logs();
        ready_i = 1'b0; base_i = 12'h800; count_i = 8'd8; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        chk("mr_busy_before", {bus.cyc_o, busy_o, valid_o}, 3'b111);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mr_async_outputs",
            {bus.cyc_o, bus.stb_o, busy_o, done_o, fail_o, valid_o, last_o}, 0);
        chk("mr_async_adr", bus.adr_o, 0);
        d0 = n_done;
        repeat (3) tick();
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        repeat (3) tick();
        chk("mr_no_done", n_done - d0, 0);
        chk("mr_fifo_lost", {valid_o, bus.cyc_o, busy_o}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
